// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard sources in, pipeline register controls out.
//   master : pipeline side (drives ID/EX observations, receives controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  // ID-stage source operands
  logic        id_valid;
  logic        id_rs1_re;
  logic        id_rs2_re;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  // EX-stage instruction
  logic        ex_rd_we;
  logic [4:0]  ex_rd_addr;
  logic        ex_is_load;
  logic        ex_mc_start;
  logic        ex_branch_taken;
  // Pipeline register controls
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_hold;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        mc_done;
  logic [31:0] stall_count;

  modport master (
    output id_valid, id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr,
           ex_rd_we, ex_rd_addr, ex_is_load, ex_mc_start, ex_branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_bubble, mc_done, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_re, id_rs2_re, id_rs1_addr, id_rs2_addr,
           ex_rd_we, ex_rd_addr, ex_is_load, ex_mc_start, ex_branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_bubble, mc_done, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32 core.
// Inserts the stall/bubble/flush cycles forwarding cannot cover:
// load-use (LOAD_LATENCY bubbles), multicycle EX ops (MC_LATENCY cycles)
// and taken branches/jumps resolved in EX.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - hazard_ctrl_if.slave (ID/EX hazard sources in, controls out)
// Controls are combinational from state, cnt and inputs; stall_count is
// registered and counts cycles with pc_stall=1 (wraps at 2^32).
module hazard_ctrl #(
  parameter int unsigned MC_LATENCY   = 4,
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned STALL_CNT_W = 32;
  localparam logic [CNT_W-1:0] MC_INIT   = CNT_W'(MC_LATENCY - 2);
  localparam logic [CNT_W-1:0] LOAD_INIT =
    (LOAD_LATENCY > 1) ? CNT_W'(LOAD_LATENCY - 2) : '0;
  localparam logic USE_LOAD_WAIT = (LOAD_LATENCY > 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MC_BUSY   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q;

  logic load_use;
  logic pc_stall, if_id_stall, if_id_flush;
  logic id_ex_hold, id_ex_bubble, ex_mem_bubble, mc_done;

  // Dependent read of a load destination still in EX; x0 never hazards.
  always_comb begin
    load_use = bus.id_valid & bus.ex_is_load & bus.ex_rd_we &
               (bus.ex_rd_addr != 5'd0) &
               ((bus.id_rs1_re & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                (bus.id_rs2_re & (bus.id_rs2_addr == bus.ex_rd_addr)));
  end

  // Next state and control outputs; reset forces every control low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_done       = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.ex_branch_taken) begin
            // Kill the two younger instructions; no added latency.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (bus.ex_mc_start) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = MC_BUSY;
            cnt_d         = MC_INIT;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            if (USE_LOAD_WAIT) begin
              state_d = LOAD_WAIT;
              cnt_d   = LOAD_INIT;
            end
          end
        end

        // EX holds a bubble here, so branch/mc inputs are meaningless.
        LOAD_WAIT: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        MC_BUSY: begin
          if (cnt_q != '0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
          end else begin
            // Final EX cycle: let the result into EX/MEM.
            mc_done = 1'b1;
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall) begin
        stall_count_q <= stall_count_q + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.pc_stall      = pc_stall;
  assign bus.if_id_stall   = if_id_stall;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_hold    = id_ex_hold;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mc_done       = mc_done;
  assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three parameterisations driven by the
// same directed stimulus, each checked every cycle against a sequence-level
// model, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0, id_rs1_re = 1'b0, id_rs2_re = 1'b0;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0;
  logic       ex_rd_we = 1'b0;
  logic [4:0] ex_rd_addr = '0;
  logic       ex_is_load = 1'b0, ex_mc_start = 1'b0, ex_branch_taken = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_hold,
  // id_ex_bubble, ex_mem_bubble, mc_done
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LOADV = 7'b1100100;
  localparam logic [6:0] MCV   = 7'b1101010;
  localparam logic [6:0] BRV   = 7'b0010100;
  localparam logic [6:0] DONEV = 7'b0000001;

  hazard_ctrl_if bus0 ();
  hazard_ctrl_if bus1 ();
  hazard_ctrl_if bus2 ();

  hazard_ctrl #(.MC_LATENCY(4), .LOAD_LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  hazard_ctrl #(.MC_LATENCY(4), .LOAD_LATENCY(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  hazard_ctrl #(.MC_LATENCY(2), .LOAD_LATENCY(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  `define TB_DRIVE(B) \
    assign B.id_valid = id_valid; assign B.id_rs1_re = id_rs1_re; \
    assign B.id_rs2_re = id_rs2_re; assign B.id_rs1_addr = id_rs1_addr; \
    assign B.id_rs2_addr = id_rs2_addr; assign B.ex_rd_we = ex_rd_we; \
    assign B.ex_rd_addr = ex_rd_addr; assign B.ex_is_load = ex_is_load; \
    assign B.ex_mc_start = ex_mc_start; assign B.ex_branch_taken = ex_branch_taken;
  `TB_DRIVE(bus0)
  `TB_DRIVE(bus1)
  `TB_DRIVE(bus2)
  `undef TB_DRIVE

  logic [6:0]  act_ctl [3];
  logic [31:0] act_cnt [3];
  assign act_ctl[0] = {bus0.pc_stall, bus0.if_id_stall, bus0.if_id_flush, bus0.id_ex_hold,
                       bus0.id_ex_bubble, bus0.ex_mem_bubble, bus0.mc_done};
  assign act_ctl[1] = {bus1.pc_stall, bus1.if_id_stall, bus1.if_id_flush, bus1.id_ex_hold,
                       bus1.id_ex_bubble, bus1.ex_mem_bubble, bus1.mc_done};
  assign act_ctl[2] = {bus2.pc_stall, bus2.if_id_stall, bus2.if_id_flush, bus2.id_ex_hold,
                       bus2.id_ex_bubble, bus2.ex_mem_bubble, bus2.mc_done};
  assign act_cnt[0] = bus0.stall_count;
  assign act_cnt[1] = bus1.stall_count;
  assign act_cnt[2] = bus2.stall_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  function automatic int ll_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int mc_of(input int i);
    case (i)
      0, 1: return 4;
      default: return 2;
    endcase
  endfunction

  // Model: an active sequence is a kind (load / multicycle) plus the number
  // of stall cycles still owed after the current one.
  localparam int K_IDLE = 0, K_LOAD = 1, K_MC = 2;
  int          m_kind [3] = '{0, 0, 0};
  int          m_left [3] = '{0, 0, 0};
  logic [31:0] m_cnt  [3] = '{0, 0, 0};

  always @(negedge clk) begin : model
    logic [6:0] e;
    logic lu;
    lu = id_valid && ex_is_load && ex_rd_we && (ex_rd_addr != 5'd0) &&
         ((id_rs1_re && id_rs1_addr == ex_rd_addr) ||
          (id_rs2_re && id_rs2_addr == ex_rd_addr));
    for (int i = 0; i < 3; i++) begin
      e = NONE;
      if (rst) begin
        m_kind[i] = K_IDLE;
        m_left[i] = 0;
      end else if (m_kind[i] == K_LOAD) begin
        e = LOADV;
        m_left[i]--;
        if (m_left[i] == 0) m_kind[i] = K_IDLE;
      end else if (m_kind[i] == K_MC) begin
        if (m_left[i] > 0) begin
          e = MCV;
          m_left[i]--;
        end else begin
          e = DONEV;
          m_kind[i] = K_IDLE;
        end
      end else if (ex_branch_taken) begin
        e = BRV;
      end else if (ex_mc_start) begin
        e = MCV;
        m_kind[i] = K_MC;
        m_left[i] = mc_of(i) - 2;
      end else if (lu) begin
        e = LOADV;
        if (ll_of(i) > 1) begin
          m_kind[i] = K_LOAD;
          m_left[i] = ll_of(i) - 1;
        end
      end
      chk($sformatf("model_ctl%0d", i), 32'(act_ctl[i]), 32'(e));
      chk($sformatf("model_cnt%0d", i), act_cnt[i], m_cnt[i]);
      if (rst) m_cnt[i] = '0;
      else if (e[6]) m_cnt[i] = m_cnt[i] + 32'd1;
    end
  end

  // Apply one cycle of inputs after the rising edge, return just past the
  // falling edge so literal checks see settled outputs.
  task automatic vec(input logic v, input logic r1e, input logic [4:0] r1,
                     input logic r2e, input logic [4:0] r2, input logic we,
                     input logic [4:0] rd, input logic ld, input logic mc,
                     input logic br);
    @(posedge clk); #1;
    id_valid = v; id_rs1_re = r1e; id_rs1_addr = r1; id_rs2_re = r2e;
    id_rs2_addr = r2; ex_rd_we = we; ex_rd_addr = rd; ex_is_load = ld;
    ex_mc_start = mc; ex_branch_taken = br;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Load x5 in EX, ID reads rs2 = x5
  task automatic load_use_x5();
    vec(1, 1, 5'd3, 1, 5'd5, 1, 5'd5, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    chk("reset_ctl0", 32'(act_ctl[0]), 32'(NONE));
    chk("reset_cnt1", act_cnt[1], 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // Load-use: 1 / 3 / 4 bubbles
    load_use_x5();
    chk("lu_first_ctl0", 32'(act_ctl[0]), 32'(LOADV));
    idle(1);
    chk("lu_after_ctl0", 32'(act_ctl[0]), 32'(NONE));
    chk("lu_wait_ctl1", 32'(act_ctl[1]), 32'(LOADV));
    idle(5);
    chk("lu_cnt0", act_cnt[0], 32'd1);
    chk("lu_cnt1", act_cnt[1], 32'd3);
    chk("lu_cnt2", act_cnt[2], 32'd4);

    // Non-hazards: rs1 match with rs1_re=0, rd_we=0, not a load
    vec(1, 0, 5'd7, 0, 5'd0, 1, 5'd7, 1, 0, 0);
    chk("no_re_ctl0", 32'(act_ctl[0]), 32'(NONE));
    vec(1, 1, 5'd7, 0, 5'd0, 0, 5'd7, 1, 0, 0);
    vec(1, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 0, 0);
    // rs1 match stalls
    vec(1, 1, 5'd9, 0, 5'd0, 1, 5'd9, 1, 0, 0);
    chk("rs1_ctl2", 32'(act_ctl[2]), 32'(LOADV));
    idle(5);

    // Multicycle op with branch on cycle 2 (ignored)
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("mc_c1_ctl0", 32'(act_ctl[0]), 32'(MCV));
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mc_c2_ctl0", 32'(act_ctl[0]), 32'(MCV));
    chk("mc_c2_ctl2", 32'(act_ctl[2]), 32'(DONEV));
    idle(1);
    chk("mc_c3_ctl1", 32'(act_ctl[1]), 32'(MCV));
    idle(1);
    chk("mc_c4_ctl0", 32'(act_ctl[0]), 32'(DONEV));
    idle(1);
    chk("mc_c5_ctl0", 32'(act_ctl[0]), 32'(NONE));
    chk("mc_cnt0", act_cnt[0], 32'd5);
    chk("mc_cnt2", act_cnt[2], 32'd9);

    // Branch beats load-use
    vec(1, 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 0, 1);
    chk("br_lu_ctl1", 32'(act_ctl[1]), 32'(BRV));
    idle(1);
    chk("br_after_ctl1", 32'(act_ctl[1]), 32'(NONE));

    // Branch beats mc_start
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("br_mc_ctl0", 32'(act_ctl[0]), 32'(BRV));

    // x0 never hazards
    vec(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0);
    chk("x0_ctl2", 32'(act_ctl[2]), 32'(NONE));

    // Reset on cycle 2 of a LOAD_LATENCY=4 wait
    load_use_x5();
    @(posedge clk); #1;
    rst = 1'b1;
    id_valid = 0; id_rs1_re = 0; id_rs2_re = 0; ex_rd_we = 0; ex_is_load = 0;
    @(negedge clk); #1;
    chk("rst_mid_ctl2", 32'(act_ctl[2]), 32'(NONE));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_after_ctl2", 32'(act_ctl[2]), 32'(NONE));
    chk("rst_after_cnt2", act_cnt[2], 32'd0);

    // Back-to-back: held load-use re-stalls immediately after each wait
    for (int k = 0; k < 8; k++) begin
      load_use_x5();
      if (k == 3) chk("b2b_c4_ctl1", 32'(act_ctl[1]), 32'(LOADV));
      if (k == 4) chk("b2b_c5_ctl2", 32'(act_ctl[2]), 32'(LOADV));
    end
    idle(4);
    chk("b2b_cnt0", act_cnt[0], 32'd8);
    chk("b2b_cnt1", act_cnt[1], 32'd9);
    chk("b2b_cnt2", act_cnt[2], 32'd8);

    // Back-to-back mc: mc_start held across the done cycle restarts at once
    for (int k = 0; k < 5; k++) vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("mc_b2b_ctl0", 32'(act_ctl[0]), 32'(MCV));
    chk("mc_b2b_ctl2", 32'(act_ctl[2]), 32'(MCV));
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
